// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into a 32-bit word and streams
// it out with an incrementing address. Define RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        done
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        out_valid_reg;
    logic [31:0] out_instr_reg;
    logic [31:0] out_addr_reg;
    logic [31:0] next_addr_reg;
    logic        err_reg;
    logic [7:0]  err_count_reg;
    logic        done_reg;
    logic        drain_done;
    logic        accept;

    logic        fit_12, fit_b, fit_j, fit_u;
    logic [31:0] enc_word;
    logic        enc_ok;

`ifdef RANGE_CHECK_EN
    // A value fits in N signed bits when all bits from N-1 upward are copies of the sign.
    assign fit_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit_b  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign fit_j  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign fit_u  = ~(|imm[11:0]);
`else
    assign fit_12 = 1'b1;
    assign fit_b  = 1'b1;
    assign fit_j  = 1'b1;
    assign fit_u  = 1'b1;
`endif

    always_comb begin
        enc_word = NOP_WORD;
        enc_ok   = 1'b0;
        case (opcode)
            OP_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_ok   = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_ok   = fit_12;
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_ok   = fit_12;
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_ok   = fit_b;
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {imm[31:12], rd, opcode};
                enc_ok   = fit_u;
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_ok   = fit_j;
            end
            default: ;
        endcase
        if (!enc_ok) begin
            enc_word = NOP_WORD;
        end
    end

    assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        drain_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_reg || out_ready) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0;
            out_addr_reg  <= BASE_ADDR;
            next_addr_reg <= BASE_ADDR;
            err_reg       <= 1'b0;
            err_count_reg <= 8'h0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= drain_done;
            if (start && state_reg == IDLE) begin
                next_addr_reg <= BASE_ADDR;
                err_reg       <= 1'b0;
                err_count_reg <= 8'h0;
            end
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_instr_reg <= enc_word;
                out_addr_reg  <= next_addr_reg;
                next_addr_reg <= next_addr_reg + 32'd4;
                // Substituted requests still consume their address slot.
                if (!enc_ok) begin
                    err_reg <= 1'b1;
                    if (err_count_reg != 8'hFF) begin
                        err_count_reg <= err_count_reg + 8'd1;
                    end
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = out_addr_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;
    assign done      = done_reg;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register fields, funct fields and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Format (R/I/S/B/U/J) is derived from the opcode.
- The immediate is range-checked and scattered into the correct bit positions.
- Encoded words stream out with an incrementing instruction-memory address; used by the program loader to fill instruction memory for the single-cycle core.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after start.
- NOP_WORD, 32'h0000_0013, substitute word for illegal or out-of-range requests (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; IDLE->RUN, address counter loaded with BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_last  in  1  marks the final request of a program.
- opcode  in  7  instruction opcode.
- rd / rs1 / rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; R-type only.
- imm  in  32  signed byte-offset immediate; U-type takes the full value with bits [11:0] zero.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  memory address for out_instr.
- err  out  1  sticky; set on any substituted request; cleared by start.
- err_count  out  8  number of substituted requests since start; saturates at 255.
- done  out  1  one-cycle pulse after the in_last word is accepted downstream.

Behaviour:
- States: IDLE, RUN, DRAIN.
  - IDLE: in_ready=0; start -> RUN.
  - RUN: accept on in_valid && in_ready; an accepted request with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0; when the output register empties -> IDLE with done=1 for that cycle.
  - start outside IDLE is ignored.
- Reset values: state IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0, done=0, in_ready=0.
- Single output register, one-cycle latency: an accepted request appears on out_instr the next cycle with out_valid=1.
- in_ready = (state==RUN) && (!out_valid || out_ready). This allows full throughput of one word per cycle under continuous out_ready.
- out_valid holds and out_instr/out_addr remain stable until out_ready is seen.
- Address:
  - First word after start carries BASE_ADDR.
  - Each subsequent accepted request uses previous address + 4.
  - 32-bit wrap (0xFFFFFFFC -> 0x0) is allowed without flagging.
- Format from opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is illegal.
- Encodings:
  - R = {funct7, rs2, rs1, funct3, rd, opcode}.
  - I = {imm[11:0], rs1, funct3, rd, opcode}.
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U = {imm[31:12], rd, opcode}.
  - J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Fields not used by a format are ignored.
- Legal immediate ranges:
  - I/S: -2048..2047.
  - B: even, -4096..4094.
  - J: even, -1048576..1048574.
  - U: imm[11:0]==0.
  - R: imm ignored.
- Illegal opcode or illegal immediate:
  - Word replaced by NOP_WORD; address still consumed.
  - err set; err_count incremented, saturating at 255.
- Reset asserted mid-stream: everything returns to reset values immediately; the in-flight word is lost.
- start in the same cycle as the final drain: done fires, state goes to IDLE, and start is ignored.

Optional Feature:
- RANGE_CHECK_EN defined: range/alignment checks as above, with NOP substitution.
- RANGE_CHECK_EN undefined:
  - No immediate checks; immediate bits are truncated/scattered as-is, ignoring the low bit for B/J and the low 12 bits for U.
  - Only an illegal opcode causes substitution and err.

Test Plan:
- start; opcode=0010011 rd=1 rs1=2 f3=0 imm=5, in_last=1, out_ready=1 -> next cycle out_instr=0x00510093, out_addr=0x0; done pulses next cycle.
- Stream of three requests, each in_last=0 except the third:
  - sw x1,4(x2): opcode=0100011 rs2=1 rs1=2 f3=2 imm=4 -> 0x00112223 @0x0.
  - beq x1,x2,0: opcode=1100011 rs1=1 rs2=2 f3=0 imm=0 -> 0x00208063 @0x4.
  - lui x5,0x12345000: opcode=0110111 rd=5 imm=0x12345000, in_last=1 -> 0x123452B7 @0x8.
- jal x1 with imm=0xFFF00000 (-1048576) -> 0x800000EF.
- addi with imm=2048 -> 0x00000013, err=1, err_count=1. With RANGE_CHECK_EN undefined -> 0x80000013 and err=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 after the first accept; out_instr/out_addr stable.
  - Release -> words emitted in order at consecutive addresses, none lost or duplicated.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, state IDLE, err_count=0 without waiting for a clock.
